universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised universal shift register, the successor of the 4-stage 1-bit serial-in/serial-out register. It provides LENGTH stages, each WIDTH bits wide, and runs one of four modes: hold, shift right, shift left, or parallel load. An optional rotate setting turns either shift into a circular shift. A saturating fill counter reports when the register holds LENGTH valid entries. It sits in the datapath as a serialiser/deserialiser, a delay line, or a tap buffer.

## Interface
- WIDTH, default 1: bits per stage; must be ≥1.
- LENGTH, default 4: number of stages; must be ≥2.
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset. Clears all stages, the counter and `filled`.
- en  input  1  clock enable. When 0, every register holds, whatever the mode.
- sclr  input  1  synchronous clear, qualified by en. It has priority over mode.
- mode  input  2  operation select: HOLD=0, SHR=1, SHL=2, LOAD=3.
- rotate  input  1  when 1, each shift wraps the exiting stage back in and ignores the serial inputs.
- sin_r  input  WIDTH  serial input for SHR; enters stage LENGTH-1.
- sin_l  input  WIDTH  serial input for SHL; enters stage 0.
- pin  input  LENGTH*WIDTH  parallel load data. Stage i takes pin[i*WIDTH +: WIDTH].
- pout  output  LENGTH*WIDTH  all stages, using the same packing as pin.
- sout_r  output  WIDTH  equals stage 0, the SHR serial output.
- sout_l  output  WIDTH  equals stage LENGTH-1, the SHL serial output.
- fill_cnt  output  $clog2(LENGTH+1)  number of shifts since the last clear, sclr or load, saturating at LENGTH.
- filled  output  1  asserted when fill_cnt == LENGTH.

## Operation
- Reset: while clear is asserted, and after it releases, all stages are 0, pout/sout_r/sout_l are 0, fill_cnt is 0 and filled is 0. This holds until the first enabled edge.
- Update priority on an enabled edge: sclr, then mode.
  - sclr=1: stages ← 0, fill_cnt ← 0. mode and rotate are ignored.
- SHR:
  - stage[i] ← stage[i+1] for i < LENGTH-1.
  - stage[LENGTH-1] ← rotate ? stage[0] : sin_r.
  - At LENGTH=4, WIDTH=1, rotate=0 this matches the legacy SISO register exactly.
- SHL:
  - stage[i] ← stage[i-1] for i > 0.
  - stage[0] ← rotate ? stage[LENGTH-1] : sin_l.
- LOAD: stage[i] ← pin slice i, and fill_cnt ← LENGTH.
- HOLD: nothing changes.
- fill_cnt rules:
  - It increments by 1 on each SHR/SHL with rotate=0, saturating at LENGTH (it never wraps).
  - A rotating shift leaves fill_cnt unchanged, because no new data enters.
  - A change of shift direction does not reset the count.
- Width rules:
  - All stage moves are whole-WIDTH words; there is no sign or bit manipulation inside a stage.
  - pin/pout packing is little-endian by stage index.
- Simultaneous events:
  - clear asserted together with en=1 has no effect beyond the reset itself.
  - sclr together with LOAD: sclr wins, giving stages=0 and fill_cnt=0.
- Reset mid-operation: clear aborts any shift sequence immediately and asynchronously. Contents are lost and are not recovered.

## Timing
- All state is registered. pout, sout_r, sout_l, fill_cnt and filled are taken directly from registers, with no combinational path from any input.
- A word presented on sin_r appears on sout_r after exactly LENGTH enabled SHR edges. The same holds for sin_l → sout_l under SHL.
- LOAD data is visible on pout one edge after the load.
- filled rises on the edge that brings fill_cnt to LENGTH.
- Deasserting en freezes every output cycle-exactly; disabled cycles do not count toward latency.
- clear release is asynchronous. The first update happens on the first rising clk after release, provided en=1.

## Structure
- Package usr_pkg holds:
  - typedef enum logic [1:0] mode_e {HOLD, SHR, SHL, LOAD};
  - the default parameter constants.
- Sub-module usr_stage: one WIDTH-bit register with a 4:1 next-value mux. Its inputs are hold, left neighbour, right neighbour and parallel slice, plus sync clear. The top level instantiates LENGTH of these in a generate loop, plus the fill counter and the rotate muxes at the two end stages.

## Test plan
- Reset: assert clear with en=1 and mode=LOAD, pin=all-ones → pout=0, fill_cnt=0 and filled=0 throughout. After release, 0 persists until an enabled edge.
- Legacy SISO (WIDTH=1, LENGTH=4): SHR with sin_r sequence 1,0,1,1 → sout_r shows 1,0,1,1 starting at the 4th edge. filled rises at edge 4 and fill_cnt holds at 4 afterwards.
- LOAD then rotate (WIDTH=4, LENGTH=4): LOAD pin=16'h4321, then 4× SHR with rotate=1 → pout sequence 1432, 2143, 3214, 4321. fill_cnt stays 4.
- SHL with en gaps (WIDTH=8): sin_l=8'hA5, then en toggles 1,0,0,1 across 4 cycles → stage 1 = 8'hA5 only after the 2nd enabled edge.
- Priority: sclr=1 together with mode=LOAD, pin nonzero → stages 0 and fill_cnt 0. Then an async clear asserted mid-shift → outputs 0 within the same cycle, with no clock edge needed.
- Direction mix: 2× SHR, then 3× SHL, rotate=0, LENGTH=4 → fill_cnt goes 1, 2, 3, 4, 4 and filled asserts on the 4th shift.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types and default sizing for the universal shift register.
package usr_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SHR  = 2'd1,
    SHL  = 2'd2,
    LOAD = 2'd3
  } mode_e;

  localparam int DEF_WIDTH  = 1;
  localparam int DEF_LENGTH = 4;

endpackage

// File: rtl/usr_stage.sv
// One WIDTH-bit stage: register with a hold/right/left/parallel next-value mux
// and a synchronous clear that overrides the mux.
module usr_stage
  import usr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             sclr_i,
  input  mode_e            sel_i,
  input  logic [WIDTH-1:0] left_i,
  input  logic [WIDTH-1:0] right_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (sclr_i) begin
      q_d = '0;
    end else begin
      case (sel_i)
        HOLD:    q_d = q_q;
        SHR:     q_d = right_i;
        SHL:     q_d = left_i;
        LOAD:    q_d = par_i;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/universal_shift_reg.sv
// LENGTH x WIDTH universal shift register (hold / shift right / shift left /
// parallel load, optional rotate) with a saturating fill counter.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LENGTH = DEF_LENGTH
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         en,
  input  logic                         sclr,
  input  logic [1:0]                   mode,
  input  logic                         rotate,
  input  logic [WIDTH-1:0]             sin_r,
  input  logic [WIDTH-1:0]             sin_l,
  input  logic [LENGTH*WIDTH-1:0]      pin,
  output logic [LENGTH*WIDTH-1:0]      pout,
  output logic [WIDTH-1:0]             sout_r,
  output logic [WIDTH-1:0]             sout_l,
  output logic [$clog2(LENGTH+1)-1:0]  fill_cnt,
  output logic                         filled
);

  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] FULL = CW'(LENGTH);

  mode_e            mode_s;
  logic [WIDTH-1:0] stage_q [LENGTH];
  logic [CW-1:0]    fill_q;
  logic [CW-1:0]    fill_d;
  logic             filled_q;

  assign mode_s = mode_e'(mode);

  // Only the two end stages see the serial inputs; rotate feeds them from the opposite end.
  for (genvar i = 0; i < LENGTH; i++) begin : g_stage
    logic [WIDTH-1:0] left_s;
    logic [WIDTH-1:0] right_s;

    if (i == 0) begin : g_left_end
      assign left_s = rotate ? stage_q[LENGTH-1] : sin_l;
    end else begin : g_left_mid
      assign left_s = stage_q[i-1];
    end

    if (i == LENGTH - 1) begin : g_right_end
      assign right_s = rotate ? stage_q[0] : sin_r;
    end else begin : g_right_mid
      assign right_s = stage_q[i+1];
    end

    usr_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i   (clk),
      .clear_i (clear),
      .en_i    (en),
      .sclr_i  (sclr),
      .sel_i   (mode_s),
      .left_i  (left_s),
      .right_i (right_s),
      .par_i   (pin[i*WIDTH +: WIDTH]),
      .q_o     (stage_q[i])
    );

    assign pout[i*WIDTH +: WIDTH] = stage_q[i];
  end

  // Rotating shifts bring in no new data, so they leave the count alone.
  always_comb begin
    fill_d = fill_q;
    if (sclr) begin
      fill_d = '0;
    end else begin
      case (mode_s)
        LOAD: fill_d = FULL;
        SHR, SHL: begin
          if (!rotate && (fill_q != FULL)) begin
            fill_d = fill_q + CW'(1);
          end else begin
            fill_d = fill_q;
          end
        end
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      fill_q   <= '0;
      filled_q <= 1'b0;
    end else if (en) begin
      fill_q   <= fill_d;
      filled_q <= (fill_d == FULL);
    end
  end

  assign sout_r   = stage_q[0];
  assign sout_l   = stage_q[LENGTH-1];
  assign fill_cnt = fill_q;
  assign filled   = filled_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboarded bench for universal_shift_reg (WIDTH=8, LENGTH=4).
module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int CW = $clog2(L + 1);

  logic             clk = 1'b0;
  logic             clear;
  logic             en;
  logic             sclr;
  logic [1:0]       mode;
  logic             rotate;
  logic [W-1:0]     sin_r;
  logic [W-1:0]     sin_l;
  logic [L*W-1:0]   pin;
  logic [L*W-1:0]   pout;
  logic [W-1:0]     sout_r;
  logic [W-1:0]     sout_l;
  logic [CW-1:0]    fill_cnt;
  logic             filled;

  universal_shift_reg #(.WIDTH(W), .LENGTH(L)) dut (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .sclr     (sclr),
    .mode     (mode),
    .rotate   (rotate),
    .sin_r    (sin_r),
    .sin_l    (sin_l),
    .pin      (pin),
    .pout     (pout),
    .sout_r   (sout_r),
    .sout_l   (sout_l),
    .fill_cnt (fill_cnt),
    .filled   (filled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L*W-1:0] pout;
    int             fill;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_st [L];
  int           m_fill;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < L; i++) m_st[i] = '0;
    m_fill = 0;
  endtask

  function automatic logic [L*W-1:0] m_pack();
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = m_st[i];
    return v;
  endfunction

  // Drive one cycle, predict with the reference model, then compare after the edge.
  task automatic step(input logic e, input logic s, input logic [1:0] md, input logic rot,
                      input logic [W-1:0] sr, input logic [W-1:0] sl, input logic [L*W-1:0] p);
    exp_t         x;
    logic [W-1:0] nx [L];
    en = e; sclr = s; mode = md; rotate = rot; sin_r = sr; sin_l = sl; pin = p;
    nx = m_st;
    if (e) begin
      if (s) begin
        for (int i = 0; i < L; i++) nx[i] = '0;
        m_fill = 0;
      end else begin
        case (md)
          2'd1: begin
            for (int i = 0; i < L - 1; i++) nx[i] = m_st[i+1];
            nx[L-1] = rot ? m_st[0] : sr;
            if (!rot && m_fill < L) m_fill++;
          end
          2'd2: begin
            for (int i = 1; i < L; i++) nx[i] = m_st[i-1];
            nx[0] = rot ? m_st[L-1] : sl;
            if (!rot && m_fill < L) m_fill++;
          end
          2'd3: begin
            for (int i = 0; i < L; i++) nx[i] = p[i*W +: W];
            m_fill = L;
          end
          default: ;
        endcase
      end
      m_st = nx;
    end
    x.pout = m_pack();
    x.fill = m_fill;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_val("pout", 64'(pout), 64'(x.pout));
    check_val("fill_cnt", 64'(fill_cnt), 64'(x.fill));
    check_val("filled", 64'(filled), 64'(x.fill == L));
    check_val("sout_r", 64'(sout_r), 64'(x.pout[W-1:0]));
    check_val("sout_l", 64'(sout_l), 64'(x.pout[L*W-1 -: W]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] siso_in [4];
    logic [W-1:0] siso_out [7];
    logic [L*W-1:0] rot_exp [4];

    // Reset held while an enabled LOAD of all-ones is presented
    clear = 1'b1; en = 1'b1; sclr = 1'b0; mode = LOAD; rotate = 1'b0;
    sin_r = '0; sin_l = '0; pin = '1;
    m_reset();
    #2;
    check_val("rst_pout_async", 64'(pout), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_val("rst_pout", 64'(pout), 64'd0);
      check_val("rst_fill", 64'(fill_cnt), 64'd0);
      check_val("rst_filled", 64'(filled), 64'd0);
    end
    clear = 1'b0;
    step(1'b0, 1'b0, LOAD, 1'b0, '0, '0, '1);
    check_val("post_rst_pout", 64'(pout), 64'd0);

    // Legacy SISO behaviour on bit-valued words
    siso_in  = '{8'h01, 8'h00, 8'h01, 8'h01};
    siso_out = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01};
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b0, SHR, 1'b0, (k < 4) ? siso_in[k] : 8'h00, '0, '0);
      check_val("siso_sout_r", 64'(sout_r), 64'(siso_out[k]));
      check_val("siso_filled", 64'(filled), (k >= 3) ? 64'd1 : 64'd0);
      check_val("siso_fill", 64'(fill_cnt), (k >= 3) ? 64'd4 : 64'(k + 1));
    end

    // LOAD then rotate right: nibble pattern 4321 rotates as 1432, 2143, 3214, 4321
    step(1'b1, 1'b0, LOAD, 1'b0, '0, '0, 32'h04030201);
    check_val("load_pout", 64'(pout), 64'h04030201);
    rot_exp = '{32'h01040302, 32'h02010403, 32'h03020104, 32'h04030201};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, SHR, 1'b1, 8'hFF, 8'hFF, '0);
      check_val("rot_pout", 64'(pout), 64'(rot_exp[k]));
      check_val("rot_fill", 64'(fill_cnt), 64'd4);
    end

    // SHL with enable gaps
    step(1'b1, 1'b1, SHL, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, SHL, 1'b0, '0, 8'hA5, '0);
    check_val("gap_s0", 64'(pout[7:0]), 64'hA5);
    check_val("gap_s1_a", 64'(pout[15:8]), 64'h00);
    step(1'b0, 1'b0, SHL, 1'b0, '0, 8'hA5, '0);
    check_val("gap_s1_b", 64'(pout[15:8]), 64'h00);
    step(1'b0, 1'b0, SHL, 1'b0, '0, 8'hA5, '0);
    check_val("gap_fill", 64'(fill_cnt), 64'd1);
    step(1'b1, 1'b0, SHL, 1'b0, '0, 8'hA5, '0);
    check_val("gap_s1_c", 64'(pout[15:8]), 64'hA5);

    // sclr beats LOAD
    step(1'b1, 1'b0, LOAD, 1'b0, '0, '0, 32'h11223344);
    step(1'b1, 1'b1, LOAD, 1'b0, '0, '0, 32'hDEADBEEF);
    check_val("sclr_pout", 64'(pout), 64'd0);
    check_val("sclr_fill", 64'(fill_cnt), 64'd0);

    // Asynchronous clear in the middle of a shift sequence
    step(1'b1, 1'b0, SHR, 1'b0, 8'h5A, '0, '0);
    step(1'b1, 1'b0, SHR, 1'b0, 8'h5A, '0, '0);
    check_val("pre_clr_pout", 64'(pout), 64'h5A5A0000);
    #2 clear = 1'b1;
    #1;
    check_val("aclr_pout", 64'(pout), 64'd0);
    check_val("aclr_fill", 64'(fill_cnt), 64'd0);
    check_val("aclr_sout_l", 64'(sout_l), 64'd0);
    #1 clear = 1'b0;
    m_reset();

    // Direction mix: count keeps climbing across a direction change
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, (k < 2) ? SHR : SHL, 1'b0, 8'h11, 8'h22, '0);
      check_val("mix_fill", 64'(fill_cnt), (k >= 3) ? 64'd4 : 64'(k + 1));
      check_val("mix_filled", 64'(filled), (k >= 3) ? 64'd1 : 64'd0);
    end

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           W'($urandom), W'($urandom), (L*W)'($urandom));
    end

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
